// File: rtl/seq_divider_restoring_if.sv
// Start/busy/done handshake bundle for the restoring divider.
// master drives operands and start, slave returns results.
interface seq_divider_restoring_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output busy,
    output done,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results and div_by_zero are held until the next accepted start.
module seq_divider_restoring #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_divider_restoring_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DZERO,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] q_d;

  // P stays below the divisor, so its top bit is always 0 and
  // only WIDTH bits are stored; the extra bit lives in shifted.
  always_comb begin
    shifted = {p_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    p_d     = shifted[WIDTH-1:0];
    q_d     = {q_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      p_d = trial[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            q_q    <= bus.dividend;
            dvs_q  <= bus.divisor;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            state_q <= (bus.divisor == '0) ? DZERO : CALC;
          end
        end
        CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quo_q   <= q_d;
            rem_q   <= p_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DZERO: begin
          // q_q still holds the untouched dividend here
          quo_q   <= '1;
          rem_q   <= q_q;
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_restoring.sv
// Scoreboard bench for seq_divider_restoring (WIDTH=4).
// Driver pushes expected results, monitor pops on every done.
module tb_seq_divider_restoring;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  logic prev_done;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           at;
  } exp_t;

  exp_t sb[$];

  seq_divider_restoring_if #(.WIDTH(W)) ifc ();

  seq_divider_restoring #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // monitor: compare every done against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (ifc.done) begin
        if (prev_done) check("done_width", 2, 1);
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("quotient", int'(ifc.quotient), int'(e.q));
          check("remainder", int'(ifc.remainder), int'(e.r));
          check("div_by_zero", int'(ifc.div_by_zero), int'(e.z));
          check("latency", cyc, e.at);
        end
      end
      prev_done = ifc.done;
    end
  end

  task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input bit push);
    exp_t e;
    @(negedge clk);
    ifc.dividend = dd;
    ifc.divisor  = dv;
    ifc.start    = 1'b1;
    @(posedge clk);
    #1;
    ifc.start    = 1'b0;
    ifc.dividend = ~dd;
    ifc.divisor  = ~dv;
    check("busy_at_accept", int'(ifc.busy), 1);
    if (push) begin
      e.q  = eq;
      e.r  = er;
      e.z  = ez;
      e.at = cyc + ((dv == '0) ? 1 : W);
      sb.push_back(e);
    end
  endtask

  // waits for done, counting busy cycles seen before it; then passes DONE edge
  task automatic wait_done(input int nb);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        seen = 1'b1;
        break;
      end
      if (ifc.busy) n++;
    end
    check("done_seen", int'(seen), 1);
    check("busy_cycles", n, nb);
    @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    total        = 0;
    bad          = 0;
    prev_done    = 1'b0;
    rst_n        = 1'b0;
    ifc.start    = 1'b0;
    ifc.dividend = '0;
    ifc.divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_quotient", int'(ifc.quotient), 0);
    check("rst_remainder", int'(ifc.remainder), 0);
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_done", int'(ifc.done), 0);
    check("rst_dbz", int'(ifc.div_by_zero), 0);
    rst_n = 1'b1;

    start_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
    wait_done(4);
    start_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b1);
    wait_done(4);
    start_op(4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 1'b1);
    wait_done(4);
    start_op(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1);
    wait_done(4);
    start_op(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1'b1);
    wait_done(1);
    start_op(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 1'b1);
    wait_done(4);

    // start held from edge k+2 through the DONE edge must be ignored
    start_op(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.dividend = 4'd7;
    ifc.divisor  = 4'd7;
    wait_done(2);
    #1;
    check("no_accept_in_done", int'(ifc.busy), 0);
    ifc.start = 1'b0;
    @(negedge clk);
    check("idle_after_done", int'(ifc.busy), 0);

    // asynchronous reset mid-division
    start_op(4'd11, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(ifc.busy), 0);
    check("arst_done", int'(ifc.done), 0);
    check("arst_quotient", int'(ifc.quotient), 0);
    check("arst_remainder", int'(ifc.remainder), 0);
    check("arst_dbz", int'(ifc.div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    start_op(4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 1'b1);
    wait_done(4);

    // all pairs at minimum spacing
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = '1;
          er = W'(a);
          ez = 1'b1;
        end else begin
          eq = W'(a / b);
          er = W'(a % b);
          ez = 1'b0;
        end
        start_op(W'(a), W'(b), eq, er, ez, 1'b1);
        wait_done((b == 0) ? 1 : W);
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
